// File: rtl/multi_clk_gen.sv
// multi_clk_gen
//   Produces CHANNELS independent divided clocks from one system clock.
//   Each channel has its own active high/low rates, a shadow config slot
//   loaded over a valid/ready port and applied only on period boundaries
//   (or on init/idle), a starting polarity loaded on init, and one-cycle
//   rise/fall strobes registered together with the clock output.
//
//   Optional feature, macro MULTI_CLK_GEN_BURST_EN: adds cfg_burst_i and
//   done_o. A nonzero burst stops the channel after that many rising edges.
//
// Ports
//   clk, sync_rst_n        system clock, synchronous active-low reset
//   clk_en                 global tick enable
//   init_i                 per-channel init pulse
//   starting_polarity_i    per-channel level loaded on init
//   generation_en_i        per-channel run enable
//   cfg_valid_i/ready_o    config handshake (ready is combinational)
//   cfg_chan_i             target channel of the config write
//   cfg_high/low_rate_i    new rates
//   cfg_burst_i            new burst count (burst build only)
//   clk_o, rise_o, fall_o  generated clocks and edge strobes
//   done_o                 burst finished (burst build only)
module multi_clk_gen #(
  parameter int CHANNELS        = 4,
  parameter int RATE_WIDTH      = 16,
  parameter int RESET_HIGH_RATE = 1,
  parameter int RESET_LOW_RATE  = 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic                  clk_en,
  input  logic [CHANNELS-1:0]   init_i,
  input  logic [CHANNELS-1:0]   starting_polarity_i,
  input  logic [CHANNELS-1:0]   generation_en_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CW-1:0]         cfg_chan_i,
  input  logic [RATE_WIDTH-1:0] cfg_high_rate_i,
  input  logic [RATE_WIDTH-1:0] cfg_low_rate_i,
`ifdef MULTI_CLK_GEN_BURST_EN
  input  logic [RATE_WIDTH-1:0] cfg_burst_i,
  output logic [CHANNELS-1:0]   done_o,
`endif
  output logic [CHANNELS-1:0]   clk_o,
  output logic [CHANNELS-1:0]   rise_o,
  output logic [CHANNELS-1:0]   fall_o
);

  localparam logic [CW:0] CH_LIM = (CW + 1)'(CHANNELS);

  // Terminal count of a phase; a rate of 0 behaves as a rate of 1.
  function automatic logic [RATE_WIDTH-1:0] term_cnt(input logic [RATE_WIDTH-1:0] rate);
    return (rate == '0) ? '0 : rate - RATE_WIDTH'(1);
  endfunction

  logic [RATE_WIDTH-1:0] r_cnt     [CHANNELS];
  logic [RATE_WIDTH-1:0] r_high    [CHANNELS];
  logic [RATE_WIDTH-1:0] r_low     [CHANNELS];
  logic [RATE_WIDTH-1:0] r_sh_high [CHANNELS];
  logic [RATE_WIDTH-1:0] r_sh_low  [CHANNELS];
  logic [RATE_WIDTH-1:0] w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0]   r_clk, r_rise, r_fall, r_pending;
  logic [CHANNELS-1:0]   w_clk_nxt, w_apply, w_wr, w_run;
  logic                  w_chan_ok, w_accept;

`ifdef MULTI_CLK_GEN_BURST_EN
  logic [RATE_WIDTH-1:0] r_sh_burst [CHANNELS];
  logic [RATE_WIDTH-1:0] r_burst    [CHANNELS];
  logic [RATE_WIDTH-1:0] r_rem      [CHANNELS];
  logic [RATE_WIDTH-1:0] w_rem_nxt  [CHANNELS];
  logic [CHANNELS-1:0]   r_done, w_done_nxt;

  // A finished burst parks the channel exactly like an idle channel.
  assign w_run  = generation_en_i & ~r_done;
  assign done_o = r_done;
`else
  assign w_run  = generation_en_i;
`endif

  assign clk_o  = r_clk;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

  // Out-of-range channel numbers are always ready and silently dropped.
  always_comb begin
    w_chan_ok   = ({1'b0, cfg_chan_i} < CH_LIM);
    cfg_ready_o = w_chan_ok ? ~r_pending[cfg_chan_i] : 1'b1;
    w_accept    = cfg_valid_i & cfg_ready_o & w_chan_ok;
    w_wr        = w_accept ? (CHANNELS'(1) << cfg_chan_i) : '0;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_clk_nxt[c] = r_clk[c];
      w_cnt_nxt[c] = r_cnt[c];
      w_apply[c]   = 1'b0;
`ifdef MULTI_CLK_GEN_BURST_EN
      w_done_nxt[c] = r_done[c];
      w_rem_nxt[c]  = r_rem[c];
`endif
      if (clk_en) begin
        if (init_i[c]) begin
          w_cnt_nxt[c] = '0;
          w_clk_nxt[c] = starting_polarity_i[c];
          w_apply[c]   = r_pending[c];
`ifdef MULTI_CLK_GEN_BURST_EN
          w_done_nxt[c] = 1'b0;
          w_rem_nxt[c]  = r_pending[c] ? r_sh_burst[c] : r_burst[c];
`endif
        end else if (w_run[c]) begin
          if (r_clk[c]) begin
            if (r_cnt[c] == term_cnt(r_high[c])) begin
              w_clk_nxt[c] = 1'b0;
              w_cnt_nxt[c] = '0;
`ifdef MULTI_CLK_GEN_BURST_EN
              if (r_burst[c] != '0 && r_rem[c] == '0) w_done_nxt[c] = 1'b1;
`endif
            end else begin
              w_cnt_nxt[c] = r_cnt[c] + RATE_WIDTH'(1);
            end
          end else if (r_cnt[c] == term_cnt(r_low[c])) begin
            // Rising edge is the period boundary: safe point to swap rates.
            w_clk_nxt[c] = 1'b1;
            w_cnt_nxt[c] = '0;
            w_apply[c]   = r_pending[c];
`ifdef MULTI_CLK_GEN_BURST_EN
            if (r_rem[c] != '0) w_rem_nxt[c] = r_rem[c] - RATE_WIDTH'(1);
`endif
          end else begin
            w_cnt_nxt[c] = r_cnt[c] + RATE_WIDTH'(1);
          end
        end else begin
          // Output is static, so a new config cannot cause a glitch.
          w_apply[c] = r_pending[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_clk     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pending <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c]  <= '0;
        r_high[c] <= RATE_WIDTH'(RESET_HIGH_RATE);
        r_low[c]  <= RATE_WIDTH'(RESET_LOW_RATE);
`ifdef MULTI_CLK_GEN_BURST_EN
        r_burst[c] <= '0;
        r_rem[c]   <= '0;
`endif
      end
`ifdef MULTI_CLK_GEN_BURST_EN
      r_done <= '0;
`endif
    end else begin
      r_clk     <= w_clk_nxt;
      r_rise    <= w_clk_nxt & ~r_clk;
      r_fall    <= ~w_clk_nxt & r_clk;
      r_pending <= w_wr | (r_pending & ~w_apply);
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c] <= w_cnt_nxt[c];
        if (w_apply[c]) begin
          r_high[c] <= r_sh_high[c];
          r_low[c]  <= r_sh_low[c];
`ifdef MULTI_CLK_GEN_BURST_EN
          r_burst[c] <= r_sh_burst[c];
`endif
        end
`ifdef MULTI_CLK_GEN_BURST_EN
        r_rem[c] <= w_rem_nxt[c];
`endif
      end
`ifdef MULTI_CLK_GEN_BURST_EN
      r_done <= w_done_nxt;
`endif
    end
  end

  // Shadow slots are pure data; pending alone says whether they are meaningful.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr[c]) begin
        r_sh_high[c] <= cfg_high_rate_i;
        r_sh_low[c]  <= cfg_low_rate_i;
`ifdef MULTI_CLK_GEN_BURST_EN
        r_sh_burst[c] <= cfg_burst_i;
`endif
      end
    end
  end

endmodule

// File: doc/multi_clk_gen.md
Name: multi_clk_gen

Overview:
- Parametrised successor of the single-channel divided-clock generator, producing CHANNELS independent divided clocks from one system clock.
- Each channel has:
  - its own active high/low rates;
  - a shadow config slot loaded through a valid/ready port and applied only at period boundaries, so rate changes are glitch-free;
  - a starting polarity applied on init;
  - one-cycle rise/fall strobes.
- Used by bench/test infrastructure and peripheral clock emulation.

Parameters:
- CHANNELS, 4, number of independent clock channels (>=1).
- RATE_WIDTH, 16, width of rate counters and rate fields.
- RESET_HIGH_RATE, 1, active high rate of every channel after reset.
- RESET_LOW_RATE, 1, active low rate of every channel after reset.

Ports:
- clk  input  1  system clock.
- sync_rst_n  input  1  synchronous active-low reset.
- clk_en  input  1  global tick enable; generation advances only when high.
- init_i  input  CHANNELS  per-channel init pulse.
- starting_polarity_i  input  CHANNELS  output level loaded on init.
- generation_en_i  input  CHANNELS  per-channel run enable.
- cfg_valid_i  input  1  config request.
- cfg_ready_o  output  1  config slot free for cfg_chan_i (combinational = ~pending[cfg_chan_i]).
- cfg_chan_i  input  $clog2(CHANNELS) (min 1)  target channel.
- cfg_high_rate_i  input  RATE_WIDTH  new high rate.
- cfg_low_rate_i  input  RATE_WIDTH  new low rate.
- clk_o  output  CHANNELS  generated clocks (registered).
- rise_o  output  CHANNELS  1-cycle strobe, same cycle clk_o goes 0->1.
- fall_o  output  CHANNELS  1-cycle strobe, same cycle clk_o goes 1->0.

Behaviour:
- **Reset** (sync_rst_n=0 at posedge):
  - clk_o=0, rise_o=0, fall_o=0, counters=0, pending=0;
  - active rates=RESET_HIGH_RATE/RESET_LOW_RATE;
  - cfg_ready_o=1 once released.
  - Reset has priority over every other event, including mid-period and mid-handshake; any unapplied shadow is discarded.
- **Rate rule:** an effective rate of 0 is treated as 1. Phase terminal is counter == eff_rate-1, compared at RATE_WIDTH with no overflow; RATE_WIDTH all-ones is a legal rate.
- **Per-channel priority** each cycle with clk_en=1: init > run > idle.
  - **Init** (init_i[c]=1): counter<=0, clk_o[c]<=starting_polarity_i[c]. If pending, the shadow is applied and pending cleared. Strobes fire if the level changes.
  - **Run** (generation_en_i[c]=1, no init): if clk_o=1 and counter==eff_high-1, then clk_o<=0, counter<=0, fall strobe. If clk_o=0 and counter==eff_low-1, then clk_o<=1, counter<=0, rise strobe, and pending shadow applied (period boundary). Otherwise counter+1.
  - **Idle** (generation_en_i[c]=0, no init): clk_o and counter hold. A pending shadow is applied this cycle.
- **clk_en=0:** all counters, clk_o and active rates freeze; rise_o/fall_o=0. The config handshake still operates.
- **Resulting waveform:** high lasts eff_high enabled ticks, low lasts eff_low enabled ticks. First edge after run begins from counter 0.
- **Config handshake:**
  - Transfer when cfg_valid_i && cfg_ready_o. Writes shadow[cfg_chan_i] and sets pending next cycle.
  - A shadow is never applied in its own accept cycle.
  - A second write to a pending channel stalls (ready=0) until the apply.
  - Writes to other channels are unaffected.
  - cfg_chan_i >= CHANNELS: ready=1, transfer accepted and dropped.
- **Channels are fully independent.** Simultaneous init/run/cfg on different channels all take effect in the same cycle.

Optional Feature:
- Macro MULTI_CLK_GEN_BURST_EN.
- **When defined**, the following ports are added:
  - cfg_burst_i (RATE_WIDTH), carried with the config;
  - done_o (CHANNELS), reset 0.
- **Burst behaviour:**
  - A nonzero burst is a count of rising edges. Each rise decrements the remaining count.
  - When it reaches 0, the channel stops at the start of the low phase after its next fall: clk_o=0, counter holds, done_o[c]=1.
  - Init reloads the remaining count from the active burst and clears done_o.
  - Burst 0 means free-running.
- **When undefined**, the ports are absent and all channels free-run.

Test Plan:
- Reset, then CHANNELS=4, all generation_en_i=1, clk_en=1, default rates 1/1 -> every clk_o toggles each cycle starting 0->1 at cycle 1; rise_o/fall_o alternate.
- Ch0 cfg high=3, low=5, then init with polarity 1 -> clk_o[0] is high 3 cycles, low 5, period 8; rise_o[0] once per 8 cycles.
- Ch1 running 2/2; cfg write to 4/1 mid-high-phase -> current period finishes at 2/2, new 4/1 waveform starts at the next rise; second write while pending sees cfg_ready_o=0 until the apply.
- Rate 0 written (high=0, low=0) -> behaves as 1/1. Rate 16'hFFFF -> high phase lasts 65535 ticks with no wrap.
- clk_en toggling 1,0,1,0 with ch2 at 2/2 -> phases stretch to 4 system cycles, strobes only in clk_en=1 cycles. sync_rst_n=0 mid-high-phase -> clk_o=0 and pending cleared the next cycle.
- With MULTI_CLK_GEN_BURST_EN: ch3 1/1 burst=3, init polarity 0 -> exactly 3 rises, then clk_o[3]=0 and done_o[3]=1 held; re-init restarts and clears done_o.
